// File: rtl/calc_ctrl_unit_p.sv
// calc_ctrl_unit_p: calculator control unit; sequences operand loads,
// single/multi-cycle ALU ops (start/done + timeout), chain mode, readout.
// Ports: i_clk, i_rst (async, active-high), i_go, i_op, i_chain, i_alu_done;
//   o_we/o_wa, o_rea/o_reb/o_raa/o_rab, o_s1, o_c, o_s2, o_alu_start,
//   o_done, o_err, o_busy, o_cs (debug state code).
module calc_ctrl_unit_p #(
  parameter int ADDR_W = 2,
  parameter int OP_W = 3,
  parameter logic [2**OP_W-1:0] MULTI_MASK = 'hF0,
  parameter int TIMEOUT = 16,
  parameter int REG_A = 1,
  parameter int REG_B = 2,
  parameter int REG_R = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_go,
  input  logic [OP_W-1:0]   i_op,
  input  logic              i_chain,
  input  logic              i_alu_done,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_wa,
  output logic              o_rea,
  output logic              o_reb,
  output logic [ADDR_W-1:0] o_raa,
  output logic [ADDR_W-1:0] o_rab,
  output logic [1:0]        o_s1,
  output logic [OP_W-1:0]   o_c,
  output logic              o_s2,
  output logic              o_alu_start,
  output logic              o_done,
  output logic              o_err,
  output logic              o_busy,
  output logic [3:0]        o_cs
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD_A = 4'd1,
    LOAD_B = 4'd2,
    DECODE = 4'd3,
    EXEC   = 4'd4,
    MSTART = 4'd5,
    MWAIT  = 4'd6,
    MWRITE = 4'd7,
    DONE   = 4'd8,
    ERR    = 4'd9
  } state_t;

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] AA = ADDR_W'(REG_A);
  localparam logic [ADDR_W-1:0] AB = ADDR_W'(REG_B);
  localparam logic [ADDR_W-1:0] AR = ADDR_W'(REG_R);

  state_t            r_cs, w_ns;
  logic [OP_W-1:0]   r_op, w_op;
  logic              r_chain, w_chain;
  logic [CW-1:0]     r_cnt, w_cnt;
  logic              r_res, w_res;

  logic              w_we, w_rea, w_reb, w_s2;
  logic              w_start, w_done, w_err;
  logic [ADDR_W-1:0] w_wa, w_raa, w_rab;
  logic [1:0]        w_s1;
  logic [OP_W-1:0]   w_c;

  always_comb begin
    w_ns    = r_cs;
    w_op    = r_op;
    w_chain = r_chain;
    w_cnt   = r_cnt;
    w_res   = r_res;
    case (r_cs)
      IDLE: if (i_go) begin
        if (i_chain && r_res) begin
          w_ns    = LOAD_B;
          w_chain = 1'b1;
        end else begin
          w_ns    = LOAD_A;
          w_chain = 1'b0;
        end
      end
      LOAD_A: w_ns = LOAD_B;
      LOAD_B: w_ns = DECODE;
      DECODE: begin
        w_op = i_op;
        w_ns = MULTI_MASK[i_op] ? MSTART : EXEC;
      end
      EXEC: w_ns = DONE;
      MSTART: begin
        w_cnt = '0;
        w_ns  = MWAIT;
      end
      // alu_done takes priority over the timeout on the last cycle
      MWAIT: begin
        if (i_alu_done)             w_ns = MWRITE;
        else if (r_cnt == CNT_LAST) w_ns = ERR;
        else                        w_cnt = r_cnt + 1'b1;
      end
      MWRITE: w_ns = DONE;
      DONE: begin
        w_res = 1'b1;
        if (!i_go) w_ns = IDLE;
      end
      ERR: begin
        w_res = 1'b0;
        if (!i_go) w_ns = IDLE;
      end
      default: w_ns = IDLE;
    endcase
  end

  // Output decode of the next state, so registered outputs track r_cs
  always_comb begin
    w_we    = 1'b0;
    w_wa    = '0;
    w_rea   = 1'b0;
    w_reb   = 1'b0;
    w_raa   = '0;
    w_rab   = '0;
    w_s1    = 2'b01;
    w_c     = '0;
    w_s2    = 1'b0;
    w_start = 1'b0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    case (w_ns)
      LOAD_A: begin
        w_s1 = 2'b11;
        w_wa = AA;
        w_we = 1'b1;
      end
      LOAD_B: begin
        w_s1 = 2'b10;
        w_wa = AB;
        w_we = 1'b1;
      end
      EXEC, MSTART, MWAIT, MWRITE: begin
        w_rea   = 1'b1;
        w_reb   = 1'b1;
        w_raa   = w_chain ? AR : AA;
        w_rab   = AB;
        w_c     = w_op;
        w_start = (w_ns == MSTART);
        if (w_ns == EXEC || w_ns == MWRITE) begin
          w_s1 = 2'b00;
          w_wa = AR;
          w_we = 1'b1;
        end
      end
      DONE: begin
        w_done = 1'b1;
        w_rea  = 1'b1;
        w_reb  = 1'b1;
        w_raa  = AR;
        w_rab  = AR;
        w_c    = w_op;
      end
      ERR: begin
        w_err = 1'b1;
        w_s2  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cs        <= IDLE;
      r_op        <= '0;
      r_chain     <= 1'b0;
      r_cnt       <= '0;
      r_res       <= 1'b0;
      o_we        <= 1'b0;
      o_wa        <= '0;
      o_rea       <= 1'b0;
      o_reb       <= 1'b0;
      o_raa       <= '0;
      o_rab       <= '0;
      o_s1        <= 2'b01;
      o_c         <= '0;
      o_s2        <= 1'b0;
      o_alu_start <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      r_cs        <= w_ns;
      r_op        <= w_op;
      r_chain     <= w_chain;
      r_cnt       <= w_cnt;
      r_res       <= w_res;
      o_we        <= w_we;
      o_wa        <= w_wa;
      o_rea       <= w_rea;
      o_reb       <= w_reb;
      o_raa       <= w_raa;
      o_rab       <= w_rab;
      o_s1        <= w_s1;
      o_c         <= w_c;
      o_s2        <= w_s2;
      o_alu_start <= w_start;
      o_done      <= w_done;
      o_err       <= w_err;
      o_busy      <= (w_ns != IDLE);
    end
  end

  assign o_cs = r_cs;

endmodule

// File: tb/tb_calc_ctrl_unit_p.sv
// tb_calc_ctrl_unit_p: transaction-level reference model feeding a
// per-cycle expectation queue; a negedge monitor pops and compares.
module tb_calc_ctrl_unit_p;

  typedef struct packed {
    logic [3:0] cs;
    logic       we;
    logic [1:0] wa;
    logic       rea;
    logic       reb;
    logic [1:0] raa;
    logic [1:0] rab;
    logic [1:0] s1;
    logic [2:0] c;
    logic       s2;
    logic       st;
    logic       done;
    logic       err;
    logic       busy;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic [2:0] op = 3'd0;
  logic       chain = 1'b0;
  logic       alu_done = 1'b0;
  logic       we, rea, reb, s2, alu_start, done, err, busy;
  logic [1:0] wa, raa, rab, s1;
  logic [2:0] c;
  logic [3:0] cs;

  int vectors = 0;
  int miscompares = 0;
  bit res_m = 1'b0;
  rec_t expq[$];
  rec_t act;

  calc_ctrl_unit_p dut (
    .i_clk(clk), .i_rst(rst), .i_go(go), .i_op(op),
    .i_chain(chain), .i_alu_done(alu_done),
    .o_we(we), .o_wa(wa), .o_rea(rea), .o_reb(reb),
    .o_raa(raa), .o_rab(rab), .o_s1(s1), .o_c(c), .o_s2(s2),
    .o_alu_start(alu_start), .o_done(done), .o_err(err),
    .o_busy(busy), .o_cs(cs)
  );

  always #5 clk = ~clk;

  assign act = {cs, we, wa, rea, reb, raa, rab, s1, c,
                s2, alu_start, done, err, busy};

  function automatic rec_t exp_out(input int st, input bit ch, input int opv);
    rec_t r;
    r = '0;
    r.cs = 4'(st);
    r.s1 = 2'b01;
    r.busy = (st != 0);
    if (st >= 4 && st <= 7) begin
      r.rea = 1; r.reb = 1;
      r.raa = ch ? 2'd3 : 2'd1;
      r.rab = 2'd2;
      r.c = 3'(opv);
    end
    case (st)
      1: begin r.s1 = 2'b11; r.wa = 2'd1; r.we = 1; end
      2: begin r.s1 = 2'b10; r.wa = 2'd2; r.we = 1; end
      4, 7: begin r.s1 = 2'b00; r.wa = 2'd3; r.we = 1; end
      5: r.st = 1;
      8: begin
        r.done = 1; r.rea = 1; r.reb = 1;
        r.raa = 2'd3; r.rab = 2'd3; r.c = 3'(opv);
      end
      9: begin r.err = 1; r.s2 = 1; end
      default: ;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      rec_t e;
      e = expq.pop_front();
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL cycle t=%0t cs=%0d: actual %h required %h",
                 $time, cs, act, e);
      end
    end
  end

  task automatic reset_check(input string nm);
    rst = 1'b1;
    go = 1'b0;
    #1;
    vectors++;
    if (act !== exp_out(0, 0, 0)) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h", nm, act, exp_out(0, 0, 0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    res_m = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      expq.push_back(exp_out(0, 0, 0));
      go = 1'b0;
      chain = 1'($urandom);
      op = 3'($urandom);
      alu_done = 1'($urandom);
    end
  endtask

  // dly: MWAIT cycle (1..16) on which alu_done rises; other values never
  task automatic run_txn(input bit ch, input int opv, input int dly,
                         input int hold, input int abort_at);
    int tr[$];
    bit eff;
    bit ok;
    int mw;
    eff = ch && res_m;
    ok = (dly >= 1 && dly <= 16);
    mw = 0;
    tr.push_back(0);
    if (!eff) tr.push_back(1);
    tr.push_back(2);
    tr.push_back(3);
    if (opv >= 4) begin
      tr.push_back(5);
      repeat (ok ? dly : 16) tr.push_back(6);
      if (ok) begin tr.push_back(7); tr.push_back(8); end
      else tr.push_back(9);
    end else begin
      tr.push_back(4);
      tr.push_back(8);
    end
    repeat (hold) tr.push_back(tr[tr.size()-1]);
    foreach (tr[i]) begin
      @(posedge clk); #1;
      if (i == abort_at) begin
        reset_check("reset_mid_op");
        return;
      end
      expq.push_back(exp_out(tr[i], eff, opv));
      go = 1'($urandom);
      chain = 1'($urandom);
      op = 3'($urandom);
      alu_done = 1'($urandom);
      case (tr[i])
        0: begin go = 1'b1; chain = ch; end
        3: op = 3'(opv);
        6: begin mw++; alu_done = (mw == dly); end
        8, 9: go = (i < tr.size() - 1);
        default: ;
      endcase
    end
    res_m = (tr[tr.size()-1] == 8);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if (act !== exp_out(0, 0, 0)) begin
      miscompares++;
      $display("FAIL reset_state: actual %h required %h", act, exp_out(0, 0, 0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    run_txn(1, 2, 0, 0, -1);
    run_txn(0, 2, 0, 2, -1);
    idle(1);
    run_txn(0, 5, 3, 0, -1);
    run_txn(0, 6, 0, 1, -1);
    run_txn(1, 3, 0, 0, -1);
    run_txn(0, 1, 0, 0, -1);
    run_txn(1, 1, 0, 0, -1);
    run_txn(0, 7, 16, 0, -1);
    run_txn(0, 5, 0, 0, 8);
    run_txn(1, 2, 0, 0, -1);
    idle(3);
    for (int k = 0; k < 150; k++) begin
      int ab;
      ab = ($urandom % 10 == 0) ? int'($urandom_range(1, 8)) : -1;
      run_txn(1'($urandom), int'($urandom % 8), int'($urandom % 18),
              int'($urandom % 3), ab);
      idle(int'($urandom % 3));
    end
    @(posedge clk); #1;
    @(negedge clk); #1;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: actual %0d left required 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
